// File: rtl/regfile_mp.sv
// Multi-port register file: 2 read / 2 write ports, optional write-to-read bypass,
// per-register busy scoreboard and a one-register-per-cycle clear sweep.
//
// state | meaning
// IDLE  | no sweep in progress, waiting for clr_req
// SWEEP | zeroing regs[idx] and busy[idx], one register per cycle
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;
  logic            sweep_en;

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_d;

  logic wen0, wen1, isn;

  // Register 0 is a sink when hardwired: its writes and issues never reach state.
  assign wen0 = we0    && !(ZERO_REG && (wa0 == '0));
  assign wen1 = we1    && !(ZERO_REG && (wa1 == '0));
  assign isn  = iss_en && !(ZERO_REG && (iss_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    sweep_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        sweep_en = 1'b1;
        idx_d    = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = (state_q == SWEEP);
  assign clr_done = done_q;

  // Priority per register: sweep zero < port 0 < port 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (sweep_en && (idx_q == AW'(i))) regs[i] <= '0;
        if (wen0 && (wa0 == AW'(i)))       regs[i] <= wd0;
        if (wen1 && (wa1 == AW'(i)))       regs[i] <= wd1;
      end
    end
  end

  // An issue names a new producer, so it overrides any clear in the same cycle.
  always_comb begin
    busy_d = busy;
    if (sweep_en) busy_d[idx_q]    = 1'b0;
    if (wen0)     busy_d[wa0]      = 1'b0;
    if (wen1)     busy_d[wa1]      = 1'b0;
    if (isn)      busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_d;
  end

  function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = regs[a];
    if (BYPASS) begin
      if (wen1 && (wa1 == a))      v = wd1;
      else if (wen0 && (wa0 == a)) v = wd0;
    end
    if (ZERO_REG && (a == '0)) v = '0;
    return v;
  endfunction

  function automatic logic read_busy(input logic [AW-1:0] a);
    logic b;
    b = busy[a];
    if (BYPASS && ((wen0 && (wa0 == a)) || (wen1 && (wa1 == a))) &&
        !(isn && (iss_addr == a)))
      b = 1'b0;
    if (ZERO_REG && (a == '0)) b = 1'b0;
    return b;
  endfunction

  assign rd1   = read_data(ra1);
  assign rd2   = read_data(ra2);
  assign busy1 = read_busy(ra1);
  assign busy2 = read_busy(ra2);

endmodule
